// File: rtl/tick_display_pkg.sv
// Shared constants for the tick-driven BCD counter and its seven-segment scan.
// Segment codes are active-low {g,f,e,d,c,b,a}; dp is added by the display mux.
package tick_display_pkg;

  localparam int NUM_DIGITS = 4;

  typedef logic [3:0] nibble_t;
  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG_0     = 7'b1000000;
  localparam seg7_t SEG_1     = 7'b1111001;
  localparam seg7_t SEG_2     = 7'b0100100;
  localparam seg7_t SEG_3     = 7'b0110000;
  localparam seg7_t SEG_4     = 7'b0011001;
  localparam seg7_t SEG_5     = 7'b0010010;
  localparam seg7_t SEG_6     = 7'b0000010;
  localparam seg7_t SEG_7     = 7'b1111000;
  localparam seg7_t SEG_8     = 7'b0000000;
  localparam seg7_t SEG_9     = 7'b0010000;
  localparam seg7_t SEG_BLANK = 7'b1111111;

  function automatic seg7_t seg_code(input nibble_t d);
    case (d)
      4'd0:    seg_code = SEG_0;
      4'd1:    seg_code = SEG_1;
      4'd2:    seg_code = SEG_2;
      4'd3:    seg_code = SEG_3;
      4'd4:    seg_code = SEG_4;
      4'd5:    seg_code = SEG_5;
      4'd6:    seg_code = SEG_6;
      4'd7:    seg_code = SEG_7;
      4'd8:    seg_code = SEG_8;
      4'd9:    seg_code = SEG_9;
      default: seg_code = SEG_BLANK;
    endcase
  endfunction

endpackage

// File: rtl/tick_bcd_display_bcd_decade.sv
// One BCD digit (0-9) that steps up or down when enabled by step & cin.
// cout includes cin so a chain of decades ripples carry/borrow.
module bcd_decade
  import tick_display_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    step,
  input  logic    dir,
  input  logic    clr,
  input  logic    cin,
  output nibble_t q,
  output logic    cout
);

  nibble_t q_q, q_d;
  logic    term;

  assign term = dir ? (q_q >= 4'd9) : (q_q == 4'd0);
  assign cout = cin & term;
  assign q    = q_q;

  always_comb begin
    q_d = q_q;
    if (clr)
      q_d = 4'd0;
    else if (step && cin) begin
      if (dir) q_d = (q_q >= 4'd9) ? 4'd0 : q_q + 4'd1;
      else     q_d = (q_q == 4'd0) ? 4'd9 : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q_q <= 4'd0;
    else     q_q <= q_d;
  end

endmodule

// File: rtl/tick_bcd_display.sv
// 4-digit BCD counter advanced by rising edges of an asynchronous slow_clk level,
// shown on a multiplexed common-anode display. Define BLANK_LEADING_ZERO_EN to blank leading zeros.
module tick_bcd_display
  import tick_display_pkg::*;
#(
  parameter int SCAN_DIV = 17
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        slow_clk,
  input  logic        en,
  input  logic        dir,
  input  logic        clr,
  output logic [15:0] bcd,
  output logic        wrap,
  output logic [7:0]  seg,
  output logic [3:0]  an
);

  logic s1_q, s2_q, s3_q;
  logic tick, step;
  logic wrap_q, wrap_d;
  logic [SCAN_DIV-1:0] scan_q;
  logic [1:0] sel;
  logic [7:0] seg_q, seg_d;
  logic [3:0] an_q, an_d;
  logic [NUM_DIGITS:0] carry;
  logic [NUM_DIGITS-1:0][3:0] digit;
  logic blank;

  // slow_clk is data: s1/s2 resolve metastability, s3 gives the edge reference
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= slow_clk;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign tick     = s2_q & ~s3_q;
  assign step     = tick & en;
  assign carry[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    bcd_decade u_dec (
      .clk  (clk),
      .rst  (rst),
      .step (step),
      .dir  (dir),
      .clr  (clr),
      .cin  (carry[g]),
      .q    (digit[g]),
      .cout (carry[g+1])
    );
  end

  assign bcd    = digit;
  assign wrap_d = ~clr & step & carry[NUM_DIGITS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrap_q <= 1'b0;
      scan_q <= '0;
    end else begin
      wrap_q <= wrap_d;
      scan_q <= scan_q + 1'b1;
    end
  end

  assign wrap = wrap_q;
  assign sel  = scan_q[SCAN_DIV-1 -: 2];

`ifdef BLANK_LEADING_ZERO_EN
  logic [NUM_DIGITS-1:0] lead_zero;
  always_comb begin
    lead_zero = '0;
    lead_zero[NUM_DIGITS-1] = (digit[NUM_DIGITS-1] == 4'd0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--)
      lead_zero[i] = lead_zero[i+1] & (digit[i] == 4'd0);
  end
  // ones digit always shows, so a zero count reads "   0"
  assign blank = (sel != 2'd0) & lead_zero[sel];
`else
  assign blank = 1'b0;
`endif

  always_comb begin
    seg_d = {1'b1, blank ? SEG_BLANK : seg_code(digit[sel])};
    an_d  = ~(4'b0001 << sel);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_q <= 8'hFF;
      an_q  <= 4'hF;
    end else begin
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg = seg_q;
  assign an  = an_q;

endmodule

// File: tb/tb_tick_bcd_display.sv
// Scoreboard bench: each tick pushes the expected {bcd, wrap, cycle}; a negedge monitor
// pops one entry whenever bcd changes or wrap is high.
module tb_tick_bcd_display;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        slow_clk = 1'b0;
  logic        en = 1'b1;
  logic        dir = 1'b1;
  logic        clr = 1'b0;
  logic [15:0] bcd;
  logic        wrap;
  logic [7:0]  seg;
  logic [3:0]  an;

  tick_bcd_display #(.SCAN_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .slow_clk (slow_clk),
    .en       (en),
    .dir      (dir),
    .clr      (clr),
    .bcd      (bcd),
    .wrap     (wrap),
    .seg      (seg),
    .an       (an)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] bcd;
    logic        wrap;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          cnt = 0;
  logic        mon_en = 1'b1;
  logic [15:0] prev_bcd = 16'h0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] to_bcd(input int v);
    to_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every visible count event must match the head of the scoreboard
  always @(negedge clk) begin
    if (!rst && mon_en && ((bcd !== prev_bcd) || wrap)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: bcd=%h wrap=%b cyc=%0d", bcd, wrap, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (bcd !== e.bcd || wrap !== e.wrap || cyc != e.cyc) begin
          errors++;
          $display("FAIL step: got bcd=%h wrap=%b cyc=%0d expected bcd=%h wrap=%b cyc=%0d",
                   bcd, wrap, cyc, e.bcd, e.wrap, e.cyc);
        end
      end
    end
    prev_bcd = bcd;
  end

  // One slow_clk rising edge; dir/clr are set in the cycle the tick is live.
  task automatic do_tick(input logic d, input logic c);
    int   n;
    logic w;
    exp_t e;
    @(posedge clk); #1;
    slow_clk = 1'b1;
    n = cyc;
    if (c) begin
      cnt = 0;
      e = '{bcd: 16'h0, wrap: 1'b0, cyc: n + 3};
      sb.push_back(e);
    end else if (en) begin
      w   = d ? (cnt == 9999) : (cnt == 0);
      cnt = d ? (cnt + 1) % 10000 : (cnt + 9999) % 10000;
      e = '{bcd: to_bcd(cnt), wrap: w, cyc: n + 3};
      sb.push_back(e);
    end
    @(posedge clk); @(posedge clk); #1;
    dir = d;
    clr = c;
    @(posedge clk); #1;
    clr = 1'b0;
    slow_clk = 1'b0;
    @(posedge clk); @(posedge clk);
  endtask

  logic [7:0] exp_seg [4];
  logic [3:0] exp_an  [4];
  logic [3:0] prev_an;
  int         guard;

  initial begin
    exp_seg[0] = 8'h90;  // 9
    exp_seg[1] = 8'hC0;  // 0
    exp_seg[2] = 8'hF9;  // 1
`ifdef BLANK_LEADING_ZERO_EN
    exp_seg[3] = 8'hFF;
`else
    exp_seg[3] = 8'hC0;
`endif
    exp_an[0] = 4'b1110; exp_an[1] = 4'b1101; exp_an[2] = 4'b1011; exp_an[3] = 4'b0111;

    repeat (3) @(posedge clk);
    #2;
    chk("reset_bcd",  {16'h0, bcd},  32'h0);
    chk("reset_wrap", {31'h0, wrap}, 32'h0);
    chk("reset_seg",  {24'h0, seg},  32'hFF);
    chk("reset_an",   {28'h0, an},   32'hF);
    @(negedge clk); rst = 1'b0;

    repeat (3) do_tick(1'b1, 1'b0);            // 0003
    repeat (4) do_tick(1'b0, 1'b0);            // down to 9999 with wrap
    do_tick(1'b1, 1'b0);                       // 0000 with wrap

    en = 1'b0;
    repeat (5) do_tick(1'b1, 1'b0);
    chk("en_off_hold", {16'h0, bcd}, 32'h0);
    en = 1'b1;

    repeat (42) do_tick(1'b1, 1'b0);
    chk("at_0042", {16'h0, bcd}, 32'h0042);
    do_tick(1'b1, 1'b1);                       // clr wins over tick

    repeat (109) do_tick(1'b1, 1'b0);
    chk("at_0109", {16'h0, bcd}, 32'h0109);

    // Align to the start of the ones-digit slot, then watch one full scan.
    guard = 0;
    prev_an = an;
    @(negedge clk);
    while (!(an == 4'b1110 && prev_an == 4'b0111) && guard < 64) begin
      prev_an = an;
      @(negedge clk);
      guard++;
    end
    chk("scan_align", {31'h0, guard < 64}, 32'h1);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("an_%0d", k),  {28'h0, an},  {28'h0, exp_an[k/4]});
      chk($sformatf("seg_%0d", k), {24'h0, seg}, {24'h0, exp_seg[k/4]});
      @(negedge clk);
    end

    repeat (20) do_tick(1'b1, 1'b0);           // 0129

    // Fast toggling: edges may be missed, count must stay valid BCD.
    mon_en = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      slow_clk = ~slow_clk;
      @(negedge clk);
      chk("bcd_valid", {31'h0, (bcd[3:0] <= 9) && (bcd[7:4] <= 9) && (bcd[11:8] <= 9) && (bcd[15:12] <= 9)}, 32'h1);
    end
    slow_clk = 1'b0;
    repeat (4) @(posedge clk);

    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    chk("async_rst_bcd", {16'h0, bcd}, 32'h0);
    chk("async_rst_seg", {24'h0, seg}, 32'hFF);
    chk("async_rst_an",  {28'h0, an},  32'hF);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    cnt = 0;
    mon_en = 1'b1;
    do_tick(1'b1, 1'b0);                       // 0001 after reset

    guard = 0;
    while (sb.size() != 0 && guard < 20) begin
      @(posedge clk);
      guard++;
    end
    chk("scoreboard_drained", sb.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
